// File: rtl/gamestate_ctrl.sv
// Frogger game flow controller: menu, play, death/level hold, game over, victory.
// Optional per-life countdown timer enabled with the GAME_TIMER_EN macro.
module gamestate_ctrl #(
  parameter int unsigned NUM_LEVELS  = 8,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned HOLD_FRAMES = 90,
  parameter int unsigned LEVEL_W     = 4,
  parameter int unsigned LIVES_W     = 3,
  parameter int unsigned TIME_FRAMES = 1800,
  parameter int unsigned TIME_W      = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [3:0]         dpad_input,
  input  logic               collision,
  input  logic               reached_end,
  output logic [2:0]         state,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic               frog_respawn,
  output logic [1:0]         soundselector,
  output logic               playsound,
  output logic [TIME_W-1:0]  time_left
);

  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_MENU       = 3'd0,
    ST_PLAYING    = 3'd1,
    ST_DYING      = 3'd2,
    ST_LEVEL_DONE = 3'd3,
    ST_GAMEOVER   = 3'd4,
    ST_VICTORY    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SND_UI_PRESS    = 2'd0,
    SND_NEXTLEVEL   = 2'd1,
    SND_CRASH       = 2'd2,
    SND_CELEBRATION = 2'd3
  } sound_t;

  state_t            st;
  logic [HOLD_W-1:0] hold_cnt;
  logic [3:0]        dpad_prev;
  logic              press_c;
  logic              hold_done_c;
  logic              respawn_c;
  logic              timeout_c;

  assign state       = st;
  assign press_c     = (|dpad_input) & ~(|dpad_prev);
  assign hold_done_c = tick && (hold_cnt == HOLD_LAST);

  // Every path that places the frog at the start row; also reloads the timer.
  assign respawn_c = ((st == ST_MENU) && press_c)
                  || ((st == ST_DYING) && hold_done_c && (lives != '0))
                  || ((st == ST_LEVEL_DONE) && hold_done_c && (level != LAST_LEVEL));

`ifdef GAME_TIMER_EN
  // A zero count while playing also counts as timeout so a deferred expiry is never lost.
  assign timeout_c = (st == ST_PLAYING)
                  && ((tick && (time_left == TIME_W'(1))) || (time_left == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      time_left <= '0;
    end else if (respawn_c) begin
      time_left <= TIME_W'(TIME_FRAMES);
    end else if ((st == ST_PLAYING) && tick && (time_left != '0)) begin
      time_left <= time_left - TIME_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
  assign time_left = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= ST_MENU;
      level         <= '0;
      lives         <= LIVES_W'(START_LIVES);
      frog_respawn  <= 1'b0;
      playsound     <= 1'b0;
      soundselector <= SND_UI_PRESS;
      hold_cnt      <= '0;
      dpad_prev     <= '0;
    end else begin
      dpad_prev    <= dpad_input;
      playsound    <= 1'b0;
      frog_respawn <= respawn_c;
      case (st)
        ST_MENU: begin
          if (press_c) begin
            st            <= ST_PLAYING;
            level         <= '0;
            lives         <= LIVES_W'(START_LIVES);
            playsound     <= 1'b1;
            soundselector <= SND_UI_PRESS;
          end
        end
        // Events wait one cycle while a cue is pulsing so cues never run back to back.
        ST_PLAYING: begin
          if (!playsound) begin
            if (collision || timeout_c) begin
              st            <= ST_DYING;
              hold_cnt      <= '0;
              lives         <= (lives == '0) ? '0 : lives - LIVES_W'(1);
              playsound     <= 1'b1;
              soundselector <= SND_CRASH;
            end else if (reached_end) begin
              st            <= ST_LEVEL_DONE;
              hold_cnt      <= '0;
              playsound     <= 1'b1;
              soundselector <= (level == LAST_LEVEL) ? SND_CELEBRATION : SND_NEXTLEVEL;
            end
          end
        end
        ST_DYING: begin
          if (tick) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_done_c) begin
              st <= (lives == '0) ? ST_GAMEOVER : ST_PLAYING;
            end
          end
        end
        ST_LEVEL_DONE: begin
          if (tick) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_done_c) begin
              if (level == LAST_LEVEL) begin
                st <= ST_VICTORY;
              end else begin
                st    <= ST_PLAYING;
                level <= level + LEVEL_W'(1);
              end
            end
          end
        end
        ST_GAMEOVER, ST_VICTORY: begin
          if (press_c) begin
            st            <= ST_MENU;
            playsound     <= 1'b1;
            soundselector <= SND_UI_PRESS;
          end
        end
        default: st <= ST_MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_gamestate_ctrl.sv
// Scoreboard bench for gamestate_ctrl: sound cues are queued as stimulus is driven
// and matched when playsound fires; state/level/lives/timer checked inline per scenario.
module tb_gamestate_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [3:0]  dpad_input;
  logic        collision;
  logic        reached_end;
  logic [2:0]  state;
  logic [3:0]  level;
  logic [2:0]  lives;
  logic        frog_respawn;
  logic [1:0]  soundselector;
  logic        playsound;
  logic [10:0] time_left;

  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  logic [1:0] exp_snd[$];
  logic ps_prev = 1'b0;

  gamestate_ctrl #(
    .NUM_LEVELS(2), .START_LIVES(2), .HOLD_FRAMES(4), .LEVEL_W(4),
    .LIVES_W(3), .TIME_FRAMES(10), .TIME_W(11)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .dpad_input(dpad_input),
    .collision(collision), .reached_end(reached_end), .state(state),
    .level(level), .lives(lives), .frog_respawn(frog_respawn),
    .soundselector(soundselector), .playsound(playsound), .time_left(time_left)
  );

  always #5 clk = ~clk;

  // Sound scoreboard and pulse monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (frog_respawn) resp_cnt++;
    if (playsound) begin
      checks++;
      if (exp_snd.size() == 0) begin
        errors++;
        $display("FAIL sound_unexpected: got sel=%0d, expected no cue", soundselector);
      end else begin
        logic [1:0] e;
        e = exp_snd.pop_front();
        if (soundselector !== e) begin
          errors++;
          $display("FAIL sound_sel: got %0d, expected %0d", soundselector, e);
        end
      end
      if (ps_prev) begin
        errors++;
        $display("FAIL playsound_b2b: got two consecutive cycles, expected one");
      end
    end
    ps_prev = playsound;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic press_release();
    dpad_input = 4'b0001;
    cyc(1);
    dpad_input = 4'b0000;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    checks++;
    if (state !== 3'd0 || level !== 4'd0 || lives !== 3'd2 || playsound !== 1'b0 ||
        frog_respawn !== 1'b0 || soundselector !== 2'd0 || time_left !== 11'd0) begin
      errors++;
      $display("FAIL reset: got st=%0d lvl=%0d lives=%0d ps=%0b fr=%0b sel=%0d t=%0d, expected 0 0 2 0 0 0 0",
               state, level, lives, playsound, frog_respawn, soundselector, time_left);
    end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_start();
    int r0;
    r0 = resp_cnt;
    exp_snd.push_back(2'd0);
    dpad_input = 4'b0001;
    cyc(5);
    dpad_input = 4'b0000;
    cyc(1);
    checks++;
    if (state !== 3'd1 || lives !== 3'd2 || level !== 4'd0) begin
      errors++;
      $display("FAIL start_state: got st=%0d lives=%0d lvl=%0d, expected 1 2 0", state, lives, level);
    end
    checks++;
    if (resp_cnt - r0 !== 1 || exp_snd.size() !== 0) begin
      errors++;
      $display("FAIL start_pulses: got respawns=%0d pending=%0d, expected 1 0", resp_cnt - r0, exp_snd.size());
    end
  endtask

  task automatic die_and_hold(input logic [2:0] exp_lives, input logic [2:0] exp_after, input bit hold_dpad);
    int r0;
    exp_snd.push_back(2'd2);
    collision = 1'b1;
    cyc(1);
    checks++;
    if (state !== 3'd2 || lives !== exp_lives) begin
      errors++;
      $display("FAIL die: got st=%0d lives=%0d, expected 2 %0d", state, lives, exp_lives);
    end
    if (hold_dpad) dpad_input = 4'b0010;
    for (int i = 0; i < 3; i++) do_tick();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL die_hold: got st=%0d, expected 2", state);
    end
    collision = 1'b0;
    r0 = resp_cnt;
    do_tick();
    cyc(1);
    checks++;
    if (state !== exp_after || resp_cnt - r0 !== ((exp_after == 3'd1) ? 1 : 0)) begin
      errors++;
      $display("FAIL die_exit: got st=%0d respawns=%0d, expected %0d", state, resp_cnt - r0, exp_after);
    end
  endtask

  task automatic test_death();
    die_and_hold(3'd1, 3'd1, 1'b0);
    die_and_hold(3'd0, 3'd4, 1'b1);
  endtask

  task automatic test_gameover_exit();
    cyc(3);
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL go_held: got st=%0d, expected 4", state);
    end
    dpad_input = 4'b0000;
    cyc(1);
    exp_snd.push_back(2'd0);
    dpad_input = 4'b0001;
    cyc(1);
    dpad_input = 4'b0000;
    checks++;
    if (state !== 3'd0 || lives !== 3'd0) begin
      errors++;
      $display("FAIL go_exit: got st=%0d lives=%0d, expected 0 0", state, lives);
    end
    cyc(1);
  endtask

  task automatic finish_level(input logic [1:0] snd, input logic [2:0] exp_after, input logic [3:0] exp_lvl);
    exp_snd.push_back(snd);
    reached_end = 1'b1;
    cyc(1);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL lvl_done: got st=%0d, expected 3", state);
    end
    for (int i = 0; i < 4; i++) do_tick();
    reached_end = 1'b0;
    cyc(1);
    checks++;
    if (state !== exp_after || level !== exp_lvl) begin
      errors++;
      $display("FAIL lvl_exit: got st=%0d lvl=%0d, expected %0d %0d", state, level, exp_after, exp_lvl);
    end
  endtask

  task automatic test_levels();
    exp_snd.push_back(2'd0);
    press_release();
    checks++;
    if (state !== 3'd1 || lives !== 3'd2 || level !== 4'd0) begin
      errors++;
      $display("FAIL new_game: got st=%0d lives=%0d lvl=%0d, expected 1 2 0", state, lives, level);
    end
    reached_end = 1'b0;
    finish_level(2'd1, 3'd1, 4'd1);
    reached_end = 1'b0;
    cyc(1);
    finish_level(2'd3, 3'd5, 4'd1);
    exp_snd.push_back(2'd0);
    press_release();
    checks++;
    if (state !== 3'd0 || level !== 4'd1) begin
      errors++;
      $display("FAIL vic_exit: got st=%0d lvl=%0d, expected 0 1", state, level);
    end
  endtask

  task automatic test_both_then_reset();
    exp_snd.push_back(2'd0);
    press_release();
    exp_snd.push_back(2'd2);
    collision = 1'b1;
    reached_end = 1'b1;
    cyc(1);
    collision = 1'b0;
    reached_end = 1'b0;
    checks++;
    if (state !== 3'd2 || level !== 4'd0 || lives !== 3'd1) begin
      errors++;
      $display("FAIL both: got st=%0d lvl=%0d lives=%0d, expected 2 0 1", state, level, lives);
    end
    do_tick();
    do_tick();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    checks++;
    if (state !== 3'd0 || level !== 4'd0 || lives !== 3'd2 || playsound !== 1'b0 ||
        frog_respawn !== 1'b0 || soundselector !== 2'd0 || time_left !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset: got st=%0d lvl=%0d lives=%0d ps=%0b fr=%0b sel=%0d t=%0d, expected 0 0 2 0 0 0 0",
               state, level, lives, playsound, frog_respawn, soundselector, time_left);
    end
    for (int i = 0; i < 3; i++) do_tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL post_reset: got st=%0d, expected 0", state);
    end
  endtask

  task automatic test_timer();
    int r0;
    exp_snd.push_back(2'd0);
    press_release();
`ifdef GAME_TIMER_EN
    checks++;
    if (time_left !== 11'd10) begin
      errors++;
      $display("FAIL timer_load: got %0d, expected 10", time_left);
    end
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) exp_snd.push_back(2'd2);
      do_tick();
      checks++;
      if (time_left !== 11'(10 - i) || state !== ((i == 10) ? 3'd2 : 3'd1)) begin
        errors++;
        $display("FAIL timer_step%0d: got t=%0d st=%0d, expected %0d %0d",
                 i, time_left, state, 10 - i, (i == 10) ? 2 : 1);
      end
    end
    checks++;
    if (lives !== 3'd1) begin
      errors++;
      $display("FAIL timer_lives: got %0d, expected 1", lives);
    end
    r0 = resp_cnt;
    for (int i = 0; i < 4; i++) do_tick();
    cyc(1);
    checks++;
    if (state !== 3'd1 || time_left !== 11'd10 || resp_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL timer_reload: got st=%0d t=%0d respawns=%0d, expected 1 10 1",
               state, time_left, resp_cnt - r0);
    end
`else
    r0 = resp_cnt;
    for (int i = 0; i < 12; i++) do_tick();
    checks++;
    if (state !== 3'd1 || time_left !== 11'd0 || lives !== 3'd2 || resp_cnt != r0) begin
      errors++;
      $display("FAIL no_timer: got st=%0d t=%0d lives=%0d, expected 1 0 2", state, time_left, lives);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    tick = 1'b0;
    dpad_input = 4'b0000;
    collision = 1'b0;
    reached_end = 1'b0;
    test_reset();
    test_start();
    test_death();
    test_gameover_exit();
    test_levels();
    test_both_then_reset();
    test_timer();
    cyc(2);
    checks++;
    if (exp_snd.size() !== 0) begin
      errors++;
      $display("FAIL sound_missing: got %0d cues never played, expected 0", exp_snd.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
